// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared widths, zero-register constant and ID/EX register layout
package id_ex_operand_stage_pkg;

  localparam int XLEN        = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int ADDR_SIZE   = 32;
  localparam int STALL_CNT_W = 32;

  localparam logic [RFIDX_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   valid;
    logic [RFIDX_WIDTH-1:0] rd;
    logic                   regwrite;
    logic                   is_load;
    logic [ADDR_SIZE-1:0]   pc;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        op1;
    logic [XLEN-1:0]        op2;
  } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_operand_fwd_mux.sv
// rtl/id_ex_operand_stage_operand_fwd_mux.sv - priority operand select: x0, EX result, MEM result, regfile
module id_ex_operand_stage_operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [RFIDX_WIDTH-1:0] src,
  input  logic [XLEN-1:0]        rf_data,
  input  logic                   ex_fwd_en,
  input  logic [RFIDX_WIDTH-1:0] ex_rd,
  input  logic [XLEN-1:0]        ex_res,
  input  logic                   mem_fwd_en,
  input  logic [RFIDX_WIDTH-1:0] mem_rd,
  input  logic [XLEN-1:0]        mem_res,
  output logic [XLEN-1:0]        operand
);

  // The younger producer (EX) wins over MEM; x0 is hardwired regardless of writers.
  always_comb begin
    if (src == REG_ZERO) begin
      operand = '0;
    end else if (ex_fwd_en && (ex_rd == src)) begin
      operand = ex_res;
    end else if (mem_fwd_en && (mem_rd == src)) begin
      operand = mem_res;
    end else begin
      operand = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID->EX operand stage: forwarding, load-use stall and ID/EX register
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [RFIDX_WIDTH-1:0] id_rs1,
  input  logic [RFIDX_WIDTH-1:0] id_rs2,
  input  logic                   id_use1,
  input  logic                   id_use2,
  input  logic [RFIDX_WIDTH-1:0] id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_is_load,
  input  logic [ADDR_SIZE-1:0]   id_pc,
  input  logic [XLEN-1:0]        id_imm,
  output logic [RFIDX_WIDTH-1:0] ra1,
  output logic [RFIDX_WIDTH-1:0] ra2,
  input  logic [XLEN-1:0]        rd1,
  input  logic [XLEN-1:0]        rd2,
  input  logic [XLEN-1:0]        ex_alu_res,
  input  logic                   mem_regwrite,
  input  logic [RFIDX_WIDTH-1:0] mem_rd,
  input  logic [XLEN-1:0]        mem_res,
  input  logic                   flush,
  input  logic                   hold,
  output logic                   id_ready,
  output logic                   ex_valid,
  output logic [RFIDX_WIDTH-1:0] ex_rd,
  output logic                   ex_regwrite,
  output logic                   ex_is_load,
  output logic [ADDR_SIZE-1:0]   ex_pc,
  output logic [XLEN-1:0]        ex_imm,
  output logic [XLEN-1:0]        ex_op1,
  output logic [XLEN-1:0]        ex_op2,
  output logic [CNT_W-1:0]       stall_cnt
);

  id_ex_t           id_ex_q, id_ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]  fwd_op1, fwd_op2;
  logic             ex_fwd_en;
  logic             load_use;

  assign ra1 = id_rs1;
  assign ra2 = id_rs2;

  assign ex_fwd_en = id_ex_q.valid & id_ex_q.regwrite;

  id_ex_operand_stage_operand_fwd_mux u_fwd_rs1 (
    .src        (id_rs1),
    .rf_data    (rd1),
    .ex_fwd_en  (ex_fwd_en),
    .ex_rd      (id_ex_q.rd),
    .ex_res     (ex_alu_res),
    .mem_fwd_en (mem_regwrite),
    .mem_rd     (mem_rd),
    .mem_res    (mem_res),
    .operand    (fwd_op1)
  );

  id_ex_operand_stage_operand_fwd_mux u_fwd_rs2 (
    .src        (id_rs2),
    .rf_data    (rd2),
    .ex_fwd_en  (ex_fwd_en),
    .ex_rd      (id_ex_q.rd),
    .ex_res     (ex_alu_res),
    .mem_fwd_en (mem_regwrite),
    .mem_rd     (mem_rd),
    .mem_res    (mem_res),
    .operand    (fwd_op2)
  );

  // A load in EX has no data yet; a dependent ID instruction must wait one cycle for MEM forwarding.
  assign load_use = id_valid & id_ex_q.valid & id_ex_q.is_load & (id_ex_q.rd != REG_ZERO) &
                    ((id_use1 & (id_rs1 == id_ex_q.rd)) | (id_use2 & (id_rs2 == id_ex_q.rd)));

  assign id_ready = ~hold & ~load_use;

  always_comb begin
    id_ex_d     = id_ex_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      id_ex_d = '0;
    end else if (hold) begin
      id_ex_d = id_ex_q;
    end else if (load_use) begin
      id_ex_d.valid    = 1'b0;
      id_ex_d.regwrite = 1'b0;
      id_ex_d.is_load  = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      id_ex_d.valid    = id_valid;
      id_ex_d.rd       = id_rd;
      id_ex_d.regwrite = id_regwrite & id_valid;
      id_ex_d.is_load  = id_is_load & id_valid;
      id_ex_d.pc       = id_pc;
      id_ex_d.imm      = id_imm;
      id_ex_d.op1      = fwd_op1;
      id_ex_d.op2      = fwd_op2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = id_ex_q.valid;
  assign ex_rd       = id_ex_q.rd;
  assign ex_regwrite = id_ex_q.regwrite;
  assign ex_is_load  = id_ex_q.is_load;
  assign ex_pc       = id_ex_q.pc;
  assign ex_imm      = id_ex_q.imm;
  assign ex_op1      = id_ex_q.op1;
  assign ex_op2      = id_ex_q.op2;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for the ID->EX operand stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use1, id_use2, id_regwrite, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd, ra1, ra2, mem_rd, ex_rd;
  logic [31:0] id_pc, id_imm, rd1, rd2, ex_alu_res, mem_res;
  logic        mem_regwrite, flush, hold, id_ready;
  logic        ex_valid, ex_regwrite, ex_is_load;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2, stall_cnt;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_pc(id_pc), .id_imm(id_imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .ex_alu_res(ex_alu_res),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_res(mem_res),
    .flush(flush), .hold(hold), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2), .stall_cnt(stall_cnt)
  );

  // mode 2: every field; mode 1: bubble (valid/regwrite/is_load/count); mode 0: valid and count only
  typedef struct {
    int          mode;
    logic        valid, rw, ld;
    logic [4:0]  rd;
    logic [31:0] pc, imm, op1, op2, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t e_full(input logic [4:0] rd, input logic rw, input logic ld,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] cnt);
    exp_t e;
    e.mode = 2; e.valid = 1'b1; e.rd = rd; e.rw = rw; e.ld = ld;
    e.pc = pc; e.imm = imm; e.op1 = op1; e.op2 = op2; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t e_bubble(input int mode, input logic [31:0] cnt);
    exp_t e;
    e = e_full(5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, cnt);
    e.mode = mode; e.valid = 1'b0;
    return e;
  endfunction

  // Monitor: the ID/EX register presents a new state every cycle; compare it against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ex_valid", ex_valid, e.valid);
        chk("stall_cnt", stall_cnt, e.cnt);
        if (e.mode >= 1) begin
          chk("ex_regwrite", ex_regwrite, e.rw);
          chk("ex_is_load", ex_is_load, e.ld);
        end
        if (e.mode == 2) begin
          chk("ex_rd", ex_rd, e.rd);
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_op1", ex_op1, e.op1);
          chk("ex_op2", ex_op2, e.op2);
        end
      end
    end
  end

  task automatic step(input exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                        input logic ld, input logic [31:0] pc, input logic [31:0] imm);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld; id_pc = pc; id_imm = imm;
  endtask

  task automatic set_mem(input logic rw, input logic [4:0] rd, input logic [31:0] res);
    mem_regwrite = rw; mem_rd = rd; mem_res = res;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cnt;
    reset = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    rd1 = '0; rd2 = '0; ex_alu_res = '0; set_mem(1'b0, 5'd0, 32'd0);
    flush = 1'b0; hold = 1'b0;
    #2;
    chk("reset ex_valid", ex_valid, 1'b0);
    chk("reset ex_pc", ex_pc, 32'd0);
    chk("reset ex_op1", ex_op1, 32'd0);
    chk("reset stall_cnt", stall_cnt, 32'd0);
    chk("reset id_ready", id_ready, 1'b1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // no hazard, destination x5
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h100, 32'h4);
    rd1 = 32'h11; rd2 = 32'h22;
    #1;
    chk("ra1", ra1, 5'd5);
    chk("ra2", ra2, 5'd6);
    chk("id_ready no hazard", id_ready, 1'b1);
    step(e_full(5'd5, 1'b1, 1'b0, 32'h100, 32'h4, 32'h11, 32'h22, 0));

    // EX and MEM both write x5: EX wins; rs2=x0 reads zero; this one writes x0
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'h104, 32'h8);
    rd1 = 32'h55; rd2 = 32'h99; ex_alu_res = 32'hAA; set_mem(1'b1, 5'd5, 32'hBB);
    step(e_full(5'd0, 1'b1, 1'b0, 32'h104, 32'h8, 32'hAA, 32'h0, 0));

    // EX writes x0: x0 source still zero, x5 falls to MEM; this one is a load to x7
    set_id(1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 32'h108, 32'hC);
    rd1 = 32'h12; rd2 = 32'h55; ex_alu_res = 32'hCC; set_mem(1'b1, 5'd5, 32'hBB);
    step(e_full(5'd7, 1'b1, 1'b1, 32'h108, 32'hC, 32'h0, 32'hBB, 0));

    // load-use on rs2=x7: one bubble, then operand comes from MEM
    set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h10C, 32'h10);
    rd1 = 32'h01; rd2 = 32'h77; set_mem(1'b0, 5'd0, 32'h0);
    #1;
    chk("id_ready load_use", id_ready, 1'b0);
    step(e_bubble(1, 1));
    set_mem(1'b1, 5'd7, 32'h700);
    #1;
    chk("id_ready after bubble", id_ready, 1'b1);
    step(e_full(5'd8, 1'b1, 1'b0, 32'h10C, 32'h10, 32'h01, 32'h700, 1));

    // load to x7, then consumer with id_rs2=x7 but id_use2=0: no stall
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h110, 32'h14);
    set_mem(1'b0, 5'd0, 32'h0);
    step(e_full(5'd7, 1'b1, 1'b1, 32'h110, 32'h14, 32'h0, 32'h0, 1));
    set_id(1'b1, 5'd8, 5'd7, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 32'h114, 32'h18);
    rd1 = 32'h88; rd2 = 32'h77; ex_alu_res = 32'hE0; set_mem(1'b1, 5'd8, 32'h800);
    #1;
    chk("id_ready unused src", id_ready, 1'b1);
    step(e_full(5'd9, 1'b1, 1'b0, 32'h114, 32'h18, 32'h800, 32'hE0, 1));

    // flush + hold + load_use together
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h118, 32'h1C);
    set_mem(1'b0, 5'd0, 32'h0);
    step(e_full(5'd7, 1'b1, 1'b1, 32'h118, 32'h1C, 32'h0, 32'h0, 1));
    set_id(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 32'h11C, 32'h0);
    flush = 1'b1; hold = 1'b1;
    #1;
    chk("id_ready flush/hold", id_ready, 1'b0);
    step(e_bubble(0, 1));
    flush = 1'b0; hold = 1'b0;

    // hold alone for three cycles freezes everything
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'h120, 32'h20);
    rd1 = 32'h11; rd2 = 32'h22;
    step(e_full(5'd11, 1'b1, 1'b0, 32'h120, 32'h20, 32'h11, 32'h22, 1));
    hold = 1'b1;
    set_id(1'b1, 5'd11, 5'd6, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 32'h124, 32'h24);
    rd1 = 32'h33; ex_alu_res = 32'hF0;
    #1;
    chk("id_ready hold", id_ready, 1'b0);
    for (int i = 0; i < 3; i++)
      step(e_full(5'd11, 1'b1, 1'b0, 32'h120, 32'h20, 32'h11, 32'h22, 1));
    hold = 1'b0;

    // four more load-use bubbles bring the counter to 5
    cnt = 1;
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h200 + 32'(i * 8), 32'h0);
      set_mem(1'b0, 5'd0, 32'h0);
      step(e_full(5'd7, 1'b1, 1'b1, 32'h200 + 32'(i * 8), 32'h0, 32'h0, 32'h0, cnt));
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 32'h204 + 32'(i * 8), 32'h0);
      cnt = cnt + 1;
      step(e_bubble(1, cnt));
    end
    set_mem(1'b1, 5'd7, 32'h7070);
    step(e_full(5'd12, 1'b1, 1'b0, 32'h21C, 32'h0, 32'h7070, 32'h0, 5));

    // drain the scoreboard, then async reset mid-cycle
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    chk("pre-reset ex_valid", ex_valid, 1'b1);
    chk("pre-reset stall_cnt", stall_cnt, 32'd5);
    reset = 1'b1;
    #1;
    chk("async reset ex_valid", ex_valid, 1'b0);
    chk("async reset stall_cnt", stall_cnt, 32'd0);
    chk("async reset ex_op1", ex_op1, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
